tile_query_arbiter: RTL and testbench

Shares the single read port of the wall tilemap between all movement requesters: the player controller and the ghost controllers. Each requester presents a position and a direction and asks whether the neighbouring tile is a wall. The block picks one request round-robin, computes the neighbour tile index, and reads the wall memory. It then returns a one-cycle acknowledge carrying the blocked bit. It sits between the movement controllers and the tilemap RAM on the game clock.

---
 rtl/tile_query_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_tile_query_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_query_arbiter.sv
// Round-robin arbiter sharing the wall-tilemap read port between movement requesters.
// Optional feature: define TILE_ARB_TUNNEL_EN to wrap the left/right grid edges.
module tile_query_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int TILE_SIZE = 20,
  parameter int TILE_COLS = 32,
  parameter int TILE_ROWS = 24,
  parameter int IDX_W     = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  input  logic [NUM_REQ*2-1:0]   req_dir,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   blocked,
  output logic [IDX_W-1:0]       nb_idx,
  output logic                   mem_rd,
  output logic [IDX_W-1:0]       mem_addr,
  input  logic                   mem_rdata,
  output logic                   busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = X_W + 1;
  localparam int RW    = Y_W + 1;
  localparam logic [CW-1:0]    COL_ONE  = CW'(1);
  localparam logic [RW-1:0]    ROW_ONE  = RW'(1);
  localparam logic [CW-1:0]    COL_LIM  = CW'(TILE_COLS);
  localparam logic [RW-1:0]    ROW_LIM  = RW'(TILE_ROWS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  dir_t               dir_q, dir_d;
  logic               oob_q, oob_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               blocked_q, blocked_d;
  logic [IDX_W-1:0]   nb_idx_q, nb_idx_d;
  logic               mem_rd_q, mem_rd_d;
  logic [IDX_W-1:0]   mem_addr_q, mem_addr_d;

  logic [PTR_W-1:0]   sel;
  logic               found;
  logic [X_W-1:0]     col;
  logic [Y_W-1:0]     row;
  logic [CW-1:0]      ncol;
  logic [RW-1:0]      nrow;
  logic               off_grid;
  logic               nb_oob;
  logic [IDX_W-1:0]   nb_calc;

  always_comb begin
    int j;
    sel   = rr_ptr_q;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = PTR_W'(j);
      end
    end
  end

  // Neighbour is one bit wider so stepping off row/col 0 lands on a huge value
  // and fails the upper-bound test instead of wrapping into the grid.
  always_comb begin
    col      = X_W'(int'(x_q) / TILE_SIZE);
    row      = Y_W'(int'(y_q) / TILE_SIZE);
    off_grid = (int'(x_q) >= TILE_COLS * TILE_SIZE) || (int'(y_q) >= TILE_ROWS * TILE_SIZE);
    ncol     = {1'b0, col};
    nrow     = {1'b0, row};
    case (dir_q)
      DIR_UP:    nrow = {1'b0, row} - ROW_ONE;
      DIR_DOWN:  nrow = {1'b0, row} + ROW_ONE;
      DIR_LEFT:  ncol = {1'b0, col} - COL_ONE;
      DIR_RIGHT: ncol = {1'b0, col} + COL_ONE;
      default:   ncol = {1'b0, col};
    endcase
`ifdef TILE_ARB_TUNNEL_EN
    if (dir_q == DIR_LEFT && col == '0) begin
      ncol = COL_LIM - COL_ONE;
    end else if (dir_q == DIR_RIGHT && ncol == COL_LIM) begin
      ncol = '0;
    end
`endif
    nb_oob  = off_grid || (ncol >= COL_LIM) || (nrow >= ROW_LIM);
    nb_calc = IDX_W'(nrow) * IDX_W'(TILE_COLS) + IDX_W'(ncol);
  end

  // The wall bit is sampled leaving DONE: covers a registered RAM (data the
  // cycle after mem_rd) as well as a combinational one, since mem_addr holds.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    oob_d      = oob_q;
    idx_d      = idx_q;
    ack_d      = '0;
    blocked_d  = blocked_q;
    nb_idx_d   = nb_idx_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = sel;
          x_d     = req_x[int'(sel)*X_W +: X_W];
          y_d     = req_y[int'(sel)*Y_W +: Y_W];
          dir_d   = dir_t'(req_dir[int'(sel)*2 +: 2]);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        oob_d = nb_oob;
        idx_d = nb_calc;
        if (!nb_oob) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = nb_calc;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        blocked_d = oob_q | mem_rdata;
        nb_idx_d  = idx_q;
        ack_d     = NUM_REQ'(1) << gnt_q;
        rr_ptr_d  = (gnt_q == PTR_LAST) ? '0 : gnt_q + 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      dir_q      <= DIR_UP;
      oob_q      <= 1'b0;
      idx_q      <= '0;
      ack_q      <= '0;
      blocked_q  <= 1'b0;
      nb_idx_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      oob_q      <= oob_d;
      idx_q      <= idx_d;
      ack_q      <= ack_d;
      blocked_q  <= blocked_d;
      nb_idx_q   <= nb_idx_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign ack      = ack_q;
  assign blocked  = blocked_q;
  assign nb_idx   = nb_idx_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_tile_query_arbiter.sv
// Self-checking bench for tile_query_arbiter: transaction-level model compared every
// cycle, plus hand-computed expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_tile_query_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int TILE_SIZE = 20;
  localparam int TILE_COLS = 32;
  localparam int TILE_ROWS = 24;
  localparam int IDX_W     = 10;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NUM_REQ-1:0]     req = '0;
  logic [NUM_REQ*X_W-1:0] req_x = '0;
  logic [NUM_REQ*Y_W-1:0] req_y = '0;
  logic [NUM_REQ*2-1:0]   req_dir = '0;
  logic [NUM_REQ-1:0]     ack;
  logic                   blocked;
  logic [IDX_W-1:0]       nb_idx;
  logic                   mem_rd;
  logic [IDX_W-1:0]       mem_addr;
  logic                   mem_rdata = 1'b0;
  logic                   busy;

  logic ram [0:1023];
  int n_cmp = 0;
  int n_fail = 0;
  int cycle = 0;
  int want [NUM_REQ];
  int ack_log[$];
  int ack_time[$];
  int ack_blk[$];
  int ack_nb[$];
  int rd_log[$];

  tile_query_arbiter #(
    .NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W), .TILE_SIZE(TILE_SIZE),
    .TILE_COLS(TILE_COLS), .TILE_ROWS(TILE_ROWS), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_dir(req_dir), .ack(ack), .blocked(blocked), .nb_idx(nb_idx),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Synchronous wall RAM: data valid only in the cycle after the read strobe.
  always @(posedge clk) mem_rdata <= mem_rd ? ram[mem_addr] : 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic checkQ(input string name, input int q[$], input int idx, input int expected);
    if (q.size() > idx) checkOutput(name, q[idx], expected);
    else begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s: got nothing expected %0d", name, expected);
    end
  endtask

  function automatic void neighbour(input int x, input int y, input int d, output bit oob, output int idx);
    int col, row, nc, nr;
    col = x / TILE_SIZE;
    row = y / TILE_SIZE;
    nc = col;
    nr = row;
    case (d)
      0: nr = row - 1;
      1: nr = row + 1;
      2: nc = col - 1;
      default: nc = col + 1;
    endcase
`ifdef TILE_ARB_TUNNEL_EN
    if (d == 2 && nc == -1) nc = TILE_COLS - 1;
    if (d == 3 && nc == TILE_COLS) nc = 0;
`endif
    oob = (x >= TILE_COLS * TILE_SIZE) || (y >= TILE_ROWS * TILE_SIZE) ||
          nr < 0 || nr >= TILE_ROWS || nc < 0 || nc >= TILE_COLS;
    idx = oob ? 0 : nr * TILE_COLS + nc;
  endfunction

  // Model: m_age counts edges since the grant; -1 means no query in flight.
  int m_age = -1, m_rr = 0, m_gnt = 0, m_idx = 0, m_nb = 0, m_addr = 0;
  bit m_oob = 0, m_blocked = 0, m_nb_known = 1, m_addr_known = 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_age = -1; m_rr = 0; m_blocked = 0; m_nb = 0; m_nb_known = 1;
      m_addr = 0; m_addr_known = 1;
    end else if (m_age == -1 || m_age == 3) begin
      m_age = -1;
      for (int o = 0; o < NUM_REQ; o++) begin
        int j;
        j = (m_rr + o) % NUM_REQ;
        if (m_age == -1 && req[j]) begin
          m_gnt = j;
          m_age = 0;
          m_addr_known = 0;
          neighbour(int'(req_x[j*X_W +: X_W]), int'(req_y[j*Y_W +: Y_W]), int'(req_dir[j*2 +: 2]), m_oob, m_idx);
        end
      end
    end else begin
      m_age++;
      if (m_age == 1 && !m_oob) begin m_addr = m_idx; m_addr_known = 1; end
      if (m_age == 3) begin
        m_blocked = m_oob ? 1'b1 : ram[m_idx];
        m_nb = m_idx;
        m_nb_known = !m_oob;
        m_addr_known = 0;
        m_rr = (m_gnt + 1) % NUM_REQ;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("busy", int'(busy), int'(m_age >= 0 && m_age <= 2));
    checkOutput("ack", int'(ack), (m_age == 3) ? (1 << m_gnt) : 0);
    checkOutput("mem_rd", int'(mem_rd), int'(m_age == 1 && !m_oob));
    if (m_addr_known) checkOutput("mem_addr", int'(mem_addr), m_addr);
    checkOutput("blocked", int'(blocked), int'(m_blocked));
    if (m_nb_known) checkOutput("nb_idx", int'(nb_idx), m_nb);
  end

  // Requester behaviour: hold req until ack, drop for one cycle, re-raise while work remains.
  always @(negedge clk) begin
    if (mem_rd) rd_log.push_back(int'(mem_addr));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) begin
        req[i] = 1'b0;
        ack_log.push_back(i);
        ack_time.push_back(cycle);
        ack_blk.push_back(int'(blocked));
        ack_nb.push_back(int'(nb_idx));
        if (want[i] > 0) want[i]--;
      end else if (!req[i] && want[i] > 0) begin
        req[i] = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input int i, input int x, input int y, input int d, input int n);
    req_x[i*X_W +: X_W] = X_W'(x);
    req_y[i*Y_W +: Y_W] = Y_W'(y);
    req_dir[i*2 +: 2]   = 2'(d);
    want[i] = n;
  endtask

  task automatic clearLogs();
    ack_log.delete(); ack_time.delete(); ack_blk.delete(); ack_nb.delete(); rd_log.delete();
  endtask

  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while ((want[0] + want[1] + want[2] + want[3] > 0 || busy || ack != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_fail++;
      $display("[TB] FAIL %s timeout: requests still pending after %0d cycles", name, budget);
      for (int i = 0; i < NUM_REQ; i++) want[i] = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) want[i] = 0;
    for (int i = 0; i < 1024; i++) ram[i] = (i % 3 == 0);
    ram[67] = 1'b0; ram[34] = 1'b1; ram[31] = 1'b1; ram[197] = 1'b1; ram[298] = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_ack", int'(ack), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single query");
    clearLogs();
    applyStimulus(0, 40, 40, 3, 1);
    waitDone("single", 40);
    checkQ("single_ack_id", ack_log, 0, 0);
    checkQ("single_nb_idx", ack_nb, 0, 67);
    checkQ("single_blocked", ack_blk, 0, 0);
    checkQ("single_rd_addr", rd_log, 0, 67);

    $display("[TB] wall hit");
    clearLogs();
    applyStimulus(0, 40, 40, 0, 1);
    waitDone("wall", 40);
    checkQ("wall_rd_addr", rd_log, 0, 34);
    checkQ("wall_blocked", ack_blk, 0, 1);
    checkQ("wall_nb_idx", ack_nb, 0, 34);

    $display("[TB] top row edge");
    clearLogs();
    applyStimulus(3, 0, 0, 0, 1);
    waitDone("top", 40);
    checkOutput("top_rd_count", rd_log.size(), 0);
    checkQ("top_ack_id", ack_log, 0, 3);
    checkQ("top_blocked", ack_blk, 0, 1);

    $display("[TB] contention");
    clearLogs();
    applyStimulus(0, 100, 100, 1, 2);
    applyStimulus(1, 300, 200, 2, 2);
    applyStimulus(3, 620, 460, 3, 2);
    waitDone("contention", 200);
    checkOutput("cont_count", ack_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      int exp_id [6];
      exp_id = '{0, 1, 3, 0, 1, 3};
      checkQ($sformatf("cont_order%0d", i), ack_log, i, exp_id[i]);
      if (i > 0 && ack_time.size() > i) checkOutput($sformatf("cont_gap%0d", i), ack_time[i] - ack_time[i-1], 4);
    end
    checkQ("cont_blk0", ack_blk, 0, 1);
    checkQ("cont_nb1", ack_nb, 1, 334);

    $display("[TB] left column edge");
    clearLogs();
    applyStimulus(0, 0, 0, 2, 1);
    waitDone("left", 40);
    checkQ("left_blocked", ack_blk, 0, 1);
`ifdef TILE_ARB_TUNNEL_EN
    checkOutput("left_rd_count", rd_log.size(), 1);
    checkQ("left_rd_addr", rd_log, 0, 31);
`else
    checkOutput("left_rd_count", rd_log.size(), 0);
`endif

    $display("[TB] off-grid x");
    clearLogs();
    applyStimulus(1, 650, 100, 2, 1);
    waitDone("offgrid", 40);
    checkOutput("offgrid_rd_count", rd_log.size(), 0);
    checkQ("offgrid_blocked", ack_blk, 0, 1);

    $display("[TB] reset mid-query");
    clearLogs();
    applyStimulus(2, 200, 200, 0, 1);
    begin
      int n;
      n = 0;
      while (!mem_rd && n < 20) begin @(negedge clk); n++; end
      checkOutput("reset_reached_wait", int'(mem_rd), 1);
    end
    #1;
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) want[i] = 0;
    req = '0;
    #1;
    checkOutput("rst_ack", int'(ack), 0);
    checkOutput("rst_mem_rd", int'(mem_rd), 0);
    checkOutput("rst_mem_addr", int'(mem_addr), 0);
    checkOutput("rst_blocked", int'(blocked), 0);
    checkOutput("rst_nb_idx", int'(nb_idx), 0);
    checkOutput("rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_no_ack", ack_log.size(), 0);
    @(posedge clk); #1;
    applyStimulus(2, 200, 200, 0, 1);
    applyStimulus(0, 40, 40, 3, 1);
    waitDone("post_reset", 60);
    checkQ("post_first", ack_log, 0, 0);
    checkQ("post_second", ack_log, 1, 2);
    checkQ("post_blk2", ack_blk, 1, 1);
    checkQ("post_nb2", ack_nb, 1, 298);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
